// File: rtl/pc_ras_fetch_if.sv
// Purpose : signal bundle between the fetch-PC generator and the rest of IF/EX.
// Latency : none, wires only.
// Backpressure: stall_D/halt_req travel in here; no valid/ready pairs.
// master = the fetch-PC generator (drives F_pc, F_valid, F_ras_hit, ras_count);
// slave  = surrounding pipeline (drives redirects, stalls, predictor and pre-decode).
interface pc_ras_fetch_if #(
  parameter int PCLEN     = 32,
  parameter int RAS_DEPTH = 4
);
  logic                         trap;
  logic                         EX_taken;
  logic [PCLEN-1:0]             EX_alt_pc;
  logic                         stall_D;
  logic                         halt_req;
  logic                         resume;
  logic [PCLEN-1:0]             F_BP_target_pc;
  logic                         F_is_call;
  logic                         F_is_ret;
  logic [PCLEN-1:0]             F_pc;
  logic                         F_valid;
  logic                         F_ras_hit;
  logic [$clog2(RAS_DEPTH):0]   ras_count;

  modport master (
    input  trap, EX_taken, EX_alt_pc, stall_D, halt_req, resume,
           F_BP_target_pc, F_is_call, F_is_ret,
    output F_pc, F_valid, F_ras_hit, ras_count
  );

  modport slave (
    output trap, EX_taken, EX_alt_pc, stall_D, halt_req, resume,
           F_BP_target_pc, F_is_call, F_is_ret,
    input  F_pc, F_valid, F_ras_hit, ras_count
  );
endinterface

// File: rtl/pc_ras_fetch.sv
// Purpose : fetch-PC register with prioritised redirect, BOOT/RUN/HALT control and a circular RAS.
// Latency : F_pc/F_valid registered (1 clk); F_ras_hit combinational from current inputs.
// Backpressure: stall_D or halt_req holds F_pc and freezes the RAS; trap/EX_taken always win.
// Ports: clk, rst_n (async, active low); fetch_if (master modport) carries
//   trap/EX_taken/EX_alt_pc, stall_D, halt_req/resume, predictor target, call/ret pre-decode in,
//   and F_pc, F_valid, F_ras_hit, ras_count out.
module pc_ras_fetch #(
  parameter int               PCLEN       = 32,
  parameter logic [PCLEN-1:0] RESET_PC    = '0,
  parameter logic [PCLEN-1:0] TRAP_PC     = PCLEN'('h100),
  parameter int               INSTR_BYTES = 4,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_ras_fetch_if.master     fetch_if
);

  localparam int TW = $clog2(RAS_DEPTH);
  localparam int CW = TW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic [PCLEN-1:0]    pc_q, pc_d;
  logic                valid_q;
  logic [TW-1:0]       top_q, top_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PCLEN-1:0]    ras_q [RAS_DEPTH];

  logic                ras_we;
  logic [TW-1:0]       ras_widx;
  logic [PCLEN-1:0]    ret_addr;
  logic [TW-1:0]       top_m1;
  logic                advance;
  logic                ras_pop;
  logic                ras_push;

  assign top_m1   = top_q - TW'(1);
  assign ret_addr = pc_q + PCLEN'(INSTR_BYTES);
  assign advance  = (state_q == RUN) && !fetch_if.trap && !fetch_if.EX_taken &&
                    !fetch_if.stall_D && !fetch_if.halt_req;
  assign ras_pop  = advance && fetch_if.F_is_ret && (cnt_q != '0);
  assign ras_push = advance && fetch_if.F_is_call;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    top_d    = top_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = top_q;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!fetch_if.trap && !fetch_if.EX_taken && !fetch_if.stall_D && fetch_if.halt_req)
          state_d = HALT;
      end
      HALT: begin
        if (fetch_if.resume || fetch_if.trap || fetch_if.EX_taken)
          state_d = RUN;
      end
      default: state_d = BOOT;
    endcase

    // Holding (BOOT/HALT/stall/halt_req) is the default: pc_d already equals pc_q.
    if (fetch_if.trap)          pc_d = TRAP_PC;
    else if (fetch_if.EX_taken) pc_d = fetch_if.EX_alt_pc;
    else if (ras_pop)           pc_d = ras_q[top_m1];
    else if (advance)           pc_d = fetch_if.F_BP_target_pc;

    // Trap flushes the stack pointer only; stale entries are harmless once count is 0.
    if (fetch_if.trap) begin
      top_d = '0;
      cnt_d = '0;
    end else if (ras_push && ras_pop) begin
      // Pop then push into the same slot: depth unchanged.
      ras_we   = 1'b1;
      ras_widx = top_m1;
    end else if (ras_push) begin
      ras_we = 1'b1;
      top_d  = top_q + TW'(1);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else if (ras_pop) begin
      top_d = top_m1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == RUN);
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      if (ras_we) ras_q[ras_widx] <= ret_addr;
    end
  end

  assign fetch_if.F_pc      = pc_q;
  assign fetch_if.F_valid   = valid_q;
  assign fetch_if.F_ras_hit = ras_pop;
  assign fetch_if.ras_count = cnt_q;

endmodule
